// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider that loads hi/lo for the HI/LO write path.
// Optional feature macro MULDIV_SIGNED_EN: when defined, sgn=1 selects two's-complement operation.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clck,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic [1:0]       state_dbg
);
  // Handshake: start is a one-cycle request honoured only while idle (busy=0);
  // done pulses for one cycle with hi/lo/div_zero valid, and busy drops the cycle after.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               op_q;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               div_by_zero;

  assign div_by_zero = op && (b == '0);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign state_dbg   = state;

`ifdef MULDIV_SIGNED_EN
  logic neg_a, neg_b, sa, sb;
  assign sa    = sgn & a[WIDTH-1];
  assign sb    = sgn & b[WIDTH-1];
  assign a_mag = sa ? ('0 - a) : a;
  assign b_mag = sb ? ('0 - b) : b;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_mag      = a;
  assign b_mag      = b;
`endif

  // One iteration of each engine; acc is {product hi, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_nx  = {mul_sum, acc[WIDTH-1:1]};
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, opnd});
    rem_sub = rem_sh[WIDTH-1:0] - opnd;
    div_nx  = {(div_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
  end

  always_comb begin
    prod = acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
    if (neg_a ^ neg_b) begin
      prod = '0 - acc;
      quo  = '0 - acc[WIDTH-1:0];
    end
    if (neg_a) rem = '0 - acc[2*WIDTH-1:WIDTH];
`endif
  end

  always_ff @(posedge clck) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = div_by_zero ? S_DONE : S_RUN;
      S_RUN:   if (cnt == CW'(1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clck) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q     <= op;
          div_zero <= div_by_zero;
          if (div_by_zero) begin
            hi <= a;
            lo <= '1;
          end else begin
            cnt  <= CW'(WIDTH);
            acc  <= {{WIDTH{1'b0}}, (op ? a_mag : b_mag)};
            opnd <= op ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            neg_a <= sa;
            neg_b <= sb;
`endif
          end
        end
        S_RUN: begin
          acc <= op_q ? div_nx : mul_nx;
          cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          if (op_q) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): directed cases plus randomized ops against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clck = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_dbg;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clck(clck), .reset(reset), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero), .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clck = ~clck;

  // reference model: plain integer arithmetic on the architectural result
  function automatic void model(input logic op_i, input logic sgn_i, input logic [W-1:0] a_i,
                                input logic [W-1:0] b_i, output logic [W-1:0] h,
                                output logic [W-1:0] l, output logic dz);
    logic use_s;
    longint sp;
    logic [2*W-1:0] up;
    int ia, ib;
    use_s = 1'b0;
`ifdef MULDIV_SIGNED_EN
    use_s = sgn_i;
`endif
    dz = 1'b0;
    if (!op_i) begin
      if (use_s) begin
        sp = longint'($signed(a_i)) * longint'($signed(b_i));
        {h, l} = sp;
      end else begin
        up = {32'd0, a_i} * {32'd0, b_i};
        {h, l} = up;
      end
    end else if (b_i == 0) begin
      h = a_i; l = '1; dz = 1'b1;
    end else if (use_s) begin
      if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
        l = a_i; h = '0;
      end else begin
        ia = a_i; ib = b_i;
        l = ia / ib; h = ia % ib;
      end
    end else begin
      l = a_i / b_i; h = a_i % b_i;
    end
  endfunction

  // driver: pulse start, scramble operands afterwards, wait (bounded) for done
  task automatic do_op(input logic op_i, input logic sgn_i, input logic [W-1:0] a_i,
                       input logic [W-1:0] b_i, output int lat, output int busy_gaps);
    bit seen;
    @(negedge clck);
    start = 1'b1; op = op_i; sgn = sgn_i; a = a_i; b = b_i;
    lat = 0; busy_gaps = 0; seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clck);
      start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
      lat++;
      if (busy !== 1'b1) busy_gaps++;
      if (done === 1'b1) seen = 1;
    end
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clck);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (hi !== '0) $display("FAIL reset_hi: got %h expected 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== '0) $display("FAIL reset_lo: got %h expected 0", lo); else pass_cnt++;
    total_cnt++; if (div_zero !== 1'b0) $display("FAIL reset_dz: got %b expected 0", div_zero); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_mul_basic();
    int lat, gaps;
    do_op(1'b0, 1'b0, 32'd7, 32'd6, lat, gaps);
    total_cnt++; if (lat != LAT) $display("FAIL mul_latency: got %0d expected %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (gaps != 0) $display("FAIL mul_busy: got %0d low cycles expected 0", gaps); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("FAIL mul_hi: got %h expected 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd42) $display("FAIL mul_lo: got %h expected 2a", lo); else pass_cnt++;
    @(negedge clck);
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mul_after_done: got busy=%b done=%b expected 0/0", busy, done); else pass_cnt++;
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, gaps);
    total_cnt++; if (hi !== 32'hFFFF_FFFE) $display("FAIL mul_full_hi: got %h expected fffffffe", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0000_0001) $display("FAIL mul_full_lo: got %h expected 00000001", lo); else pass_cnt++;
  endtask

  task automatic test_divide();
    int lat, gaps;
    do_op(1'b1, 1'b0, 32'd100, 32'd7, lat, gaps);
    total_cnt++; if (lat != LAT) $display("FAIL div_latency: got %0d expected %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (lo !== 32'd14) $display("FAIL div_lo: got %h expected e", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd2) $display("FAIL div_hi: got %h expected 2", hi); else pass_cnt++;
    total_cnt++; if (div_zero !== 1'b0) $display("FAIL div_dz: got %b expected 0", div_zero); else pass_cnt++;
    do_op(1'b1, 1'b0, 32'd5, 32'd0, lat, gaps);
    total_cnt++; if (lat != 1) $display("FAIL dz_latency: got %0d expected 1", lat); else pass_cnt++;
    total_cnt++; if (div_zero !== 1'b1) $display("FAIL dz_flag: got %b expected 1", div_zero); else pass_cnt++;
    total_cnt++; if (hi !== 32'd5) $display("FAIL dz_hi: got %h expected 5", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFF_FFFF) $display("FAIL dz_lo: got %h expected ffffffff", lo); else pass_cnt++;
    repeat (3) @(negedge clck);
    total_cnt++; if (div_zero !== 1'b1) $display("FAIL dz_hold: got %b expected 1", div_zero); else pass_cnt++;
    do_op(1'b0, 1'b0, 32'd3, 32'd3, lat, gaps);
    total_cnt++; if (div_zero !== 1'b0) $display("FAIL dz_clear: got %b expected 0", div_zero); else pass_cnt++;
  endtask

  task automatic test_signed();
    int lat, gaps;
`ifdef MULDIV_SIGNED_EN
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3, lat, gaps);
    total_cnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL smul_hi: got %h expected ffffffff", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFF_FFEB) $display("FAIL smul_lo: got %h expected ffffffeb", lo); else pass_cnt++;
    do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, gaps);
    total_cnt++; if (lo !== 32'hFFFF_FFFD) $display("FAIL sdiv_lo: got %h expected fffffffd", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL sdiv_hi: got %h expected ffffffff", hi); else pass_cnt++;
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, gaps);
    total_cnt++; if (lo !== 32'h8000_0000) $display("FAIL sdiv_mn_lo: got %h expected 80000000", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("FAIL sdiv_mn_hi: got %h expected 0", hi); else pass_cnt++;
`else
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3, lat, gaps);
    total_cnt++; if (hi !== 32'd2) $display("FAIL usgn_hi: got %h expected 2", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFF_FFEB) $display("FAIL usgn_lo: got %h expected ffffffeb", lo); else pass_cnt++;
`endif
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] eh, el;
    logic edz;
    int lat;
    bit seen;
    model(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, eh, el, edz);
    @(negedge clck);
    start = 1'b1; op = 1'b1; sgn = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_1234;
    lat = 0; seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clck);
      lat++;
      start = (lat == 10);
      op = 1'b0; a = 32'd1; b = 32'd1;
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    total_cnt++; if (!seen || lat != LAT) $display("FAIL ign_latency: got %0d expected %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (lo !== el) $display("FAIL ign_lo: got %h expected %h", lo, el); else pass_cnt++;
    total_cnt++; if (hi !== eh) $display("FAIL ign_hi: got %h expected %h", hi, eh); else pass_cnt++;
    repeat (2) @(negedge clck);
    total_cnt++; if (busy !== 1'b0) $display("FAIL ign_not_queued: got busy=%b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eh, el;
    logic edz;
    int lat, gaps;
    do_op(1'b0, 1'b0, 32'd1000, 32'd1000, lat, gaps);
    model(1'b1, 1'b0, 32'd99999, 32'd17, eh, el, edz);
    do_op(1'b1, 1'b0, 32'd99999, 32'd17, lat, gaps);
    total_cnt++; if (lat != LAT) $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (lo !== el || hi !== eh)
      $display("FAIL b2b_result: got %h/%h expected %h/%h", hi, lo, eh, el); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, gaps, done_seen;
    do_op(1'b0, 1'b0, 32'h0001_0003, 32'h0002_0005, lat, gaps);
    @(negedge clck);
    start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clck);
      start = 1'b0;
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clck);
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== '0 || lo !== '0)
      $display("FAIL rst_mid_hilo: got %h/%h expected 0/0", hi, lo); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", done); else pass_cnt++;
    reset = 1'b0; start = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clck);
      if (done === 1'b1) done_seen++;
    end
    total_cnt++; if (done_seen != 0) $display("FAIL rst_mid_nodone: got %0d done pulses expected 0", done_seen); else pass_cnt++;
  endtask

  // scoreboard: expected hi/lo pushed from the model, popped against observed outputs
  task automatic test_random();
    logic [W-1:0] eh, el, ra, rb, qh, ql;
    logic edz, rop, rsg;
    int lat, gaps, exp_lat;
    for (int n = 0; n < 40; n++) begin
      rop = 1'($urandom_range(0, 1));
      rsg = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      model(rop, rsg, ra, rb, eh, el, edz);
      exp_q.push_back(el);
      exp_q.push_back(eh);
      exp_lat = (rop && rb == 0) ? 1 : LAT;
      do_op(rop, rsg, ra, rb, lat, gaps);
      ql = exp_q.pop_front();
      qh = exp_q.pop_front();
      total_cnt++; if (lo !== ql)
        $display("FAIL rnd_lo[%0d] op=%b sgn=%b a=%h b=%h: got %h expected %h", n, rop, rsg, ra, rb, lo, ql); else pass_cnt++;
      total_cnt++; if (hi !== qh)
        $display("FAIL rnd_hi[%0d] op=%b sgn=%b a=%h b=%h: got %h expected %h", n, rop, rsg, ra, rb, hi, qh); else pass_cnt++;
      total_cnt++; if (div_zero !== edz || lat != exp_lat || gaps != 0)
        $display("FAIL rnd_ctl[%0d]: got dz=%b lat=%0d gaps=%0d expected dz=%b lat=%0d gaps=0",
                 n, div_zero, lat, gaps, edz, exp_lat); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_divide();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the multicycle datapath. It replaces the fixed single-width mult/div handling that the control FSM sequences with a self-timed engine. The FSM issues a one-cycle `start`, waits on `busy`/`done`, and reads the `hi`/`lo` registers that feed the HI/LO write path. Divide-by-zero is flagged on `div_zero` so the FSM can route it to its exception state.

## Interface
- `WIDTH`, 32: operand width in bits; legal values are 4..64, even.
- `clck` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin an operation; sampled only in IDLE.
- `op` in 1: 0 = multiply, 1 = divide; captured with `start`.
- `sgn` in 1: signed operation request; captured with `start` (see Configuration).
- `a` in WIDTH: multiplicand / dividend; captured with `start`.
- `b` in WIDTH: multiplier / divisor; captured with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle pulse; `hi`, `lo` and `div_zero` are valid from this cycle on.
- `hi` out WIDTH: multiply gives product[2W-1:W]; divide gives remainder.
- `lo` out WIDTH: multiply gives product[W-1:0]; divide gives quotient.
- `div_zero` out 1: set with `done` when a divide had `b == 0`; held until the next accepted `start`.

## Operation
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_zero`=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: on `start`, capture `op`/`sgn`/`a`/`b`, clear `div_zero`, and take one of two exits:
    - divide with `b == 0` → DONE.
    - otherwise → RUN, with counter = WIDTH.
- RUN performs one step per cycle, decrements the counter, and goes to FIX when the counter reaches 0.
  - Multiply step: unsigned shift-add. If the multiplier LSB is 1, add the multiplicand to the upper half of the 2W accumulator, keeping the carry. Then shift the {carry, accumulator} right by 1.
  - Divide step: restoring. Shift {remainder, quotient} left by 1, trial-subtract the divisor from the remainder, keep the difference if it is non-negative, and set the quotient LSB to the result of that test.
- FIX: apply sign correction (Configuration), load `hi`/`lo`, go to DONE.
- DONE: pulse `done`, go to IDLE.
- Divide by zero: `hi` = `a` (unmodified), `lo` = all ones, `div_zero` = 1.
- `start` while not in IDLE is ignored; it is neither queued nor able to corrupt the current operation.
- `hi`/`lo` hold their last result until the next FIX or DONE loads them. They are not cleared by a new `start`.
- `reset` asserted mid-operation returns to IDLE on the next edge with all outputs at their reset values. No `done` is produced.
- All arithmetic is modulo 2^WIDTH per output word. No overflow flag exists.

## Timing
- `start` accepted at edge 0 (IDLE).
- Normal operation:
  - `busy`=1 from edge 1.
  - RUN occupies edges 1..WIDTH.
  - FIX is at edge WIDTH+1.
  - `done`=1 after edge WIDTH+2.
  - Latency from start to done is WIDTH+2 cycles (34 for WIDTH=32).
- Divide by zero: `done`=1 after edge 1 (latency 1 cycle).
- `busy` drops in the cycle after `done`. A new `start` is accepted in that same cycle.
- When `reset` and `start` are both high, `reset` wins.

## Configuration
- `MULDIV_SIGNED_EN`:
  - Defined: `sgn`=1 selects two's-complement operation.
    - Operands are converted to magnitudes in IDLE.
    - In FIX, the product is negated across 2W bits if the operand signs differ.
    - The quotient is negated if the signs differ.
    - The remainder takes the dividend's sign.
    - Most-negative ÷ −1 gives `lo` = most-negative and `hi` = 0.
  - Undefined: `sgn` is ignored, all operations are unsigned, and no negation logic is present.

## Test plan
- Unsigned multiply, WIDTH=32: `a`=7, `b`=6 → `done` exactly 34 cycles after `start`; `hi`=0, `lo`=42; `busy` is high for cycles 1–34.
- Unsigned multiply, full range: `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Divide by zero: `op`=1, `a`=100, `b`=7 → `lo`=14, `hi`=2. Then `a`=5, `b`=0 → `done` after 1 cycle, `div_zero`=1, `hi`=5, `lo`=0xFFFFFFFF.
- Signed, with `MULDIV_SIGNED_EN`:
  - −7 × 3 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - −7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - 0x80000000 ÷ −1 → `lo`=0x80000000, `hi`=0.
- Signed request, macro undefined: `sgn`=1, `a`=0xFFFFFFF9, `b`=3, multiply → `hi`=2, `lo`=0xFFFFFFEB (unsigned result).
- Robustness:
  - A second `start` (`a`=1, `b`=1) pulsed at cycle 10 of an operation is ignored; the first result is unchanged.
  - `reset` at cycle 20 → no `done`; `hi`=`lo`=0 and `busy`=0 on the next cycle.
